dmem_stall: RTL and testbench

Parametrised multi-cycle data memory for the ME stage of the 5-stage pipeline; it is the successor to the single-cycle data memory. It models a configurable access latency and raises a stall that freezes the whole pipeline until the access completes. Width, depth, latency and byte-lane write masking are parameters. A saturating access counter is provided for performance measurement.

---
 rtl/dmem_stall.sv | 116 +++++++++++
 tb/tb_dmem_stall.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_stall.sv
// ME-stage data memory with a configurable access latency and a pipeline stall.
// Byte-lane write masking, aliasing word index and a saturating access counter.
module dmem_stall #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clock,
    input  logic                reset_0,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                rmem,
    input  logic                wmem,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata,
    output logic                stall,
    output logic [CNT_W-1:0]    acc_cnt
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned Depth    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LastCnt  = 4'(LATENCY) - 4'd1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              lat_q, lat_d;
    logic [DATA_W-1:0]       rdata_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       mem [Depth];
    logic [DEPTH_LOG2-1:0]   idx;
    logic                    req;
    logic                    commit;
    logic                    unused_addr;

    assign req         = rmem | wmem;
    assign idx         = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+2], addr[1:0]};

    // commit marks the edge on which the access takes effect (entering DONE)
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        commit  = 1'b0;
        if (LATENCY == 0) begin
            commit = req;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req) begin
                        lat_d = 4'd0;
                        if (LATENCY == 1) begin
                            state_d = StDone;
                            commit  = 1'b1;
                        end else begin
                            state_d = StBusy;
                        end
                    end
                end
                StBusy: begin
                    lat_d = lat_q + 4'd1;
                    if (lat_d == LastCnt) begin
                        state_d = StDone;
                        commit  = 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset_0) begin
        if (reset_0) begin
            state_q <= StIdle;
            lat_q   <= 4'd0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (commit && rmem) begin
                rdata_q <= mem[idx];
            end
            if (commit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Array is deliberately not reset; an aborted access never reaches commit
    always_ff @(posedge clock) begin
        if (commit && wmem && !reset_0) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        if (LATENCY == 0) begin
            stall = 1'b0;
            rdata = reset_0 ? '0 : mem[idx];
        end else begin
            stall = !reset_0 && req && (state_q != StDone);
            rdata = rdata_q;
        end
    end

    assign acc_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_stall.sv
// Directed bench for dmem_stall: LATENCY=3 (CNT_W=4) instance plus a LATENCY=0 instance,
// with a word-level reference memory feeding an expected-rdata queue.
module tb_dmem_stall;

    logic        clk;
    logic        rst;
    logic [31:0] addr, wdata;
    logic        rmem, wmem;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        stall;
    logic [3:0]  acc_cnt;

    logic [31:0] addr0, wdata0;
    logic        rmem0, wmem0;
    logic [3:0]  be0;
    logic [31:0] rdata0;
    logic        stall0;
    logic [15:0] acc_cnt0;

    int          n_vec;
    int          n_err;
    logic [31:0] exp_q[$];
    logic [31:0] model[int];

    dmem_stall #(.LATENCY(3), .CNT_W(4)) u_dut (
        .clock(clk), .reset_0(rst), .addr(addr), .rmem(rmem), .wmem(wmem),
        .wdata(wdata), .be(be), .rdata(rdata), .stall(stall), .acc_cnt(acc_cnt)
    );

    dmem_stall #(.LATENCY(0)) u_dut0 (
        .clock(clk), .reset_0(rst), .addr(addr0), .rmem(rmem0), .wmem(wmem0),
        .wdata(wdata0), .be(be0), .rdata(rdata0), .stall(stall0), .acc_cnt(acc_cnt0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] m;
        m = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
        for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
        model[widx(a)] = m;
    endtask

    // Presents one access at posedge+1, counts stall cycles, checks the DONE cycle.
    task automatic access(input string tag, input logic [31:0] a, input logic r, input logic w,
                          input logic [31:0] d, input logic [3:0] b);
        int n;
        logic [31:0] e;
        addr = a; rmem = r; wmem = w; wdata = d; be = b;
        if (r) exp_q.push_back(model[widx(a)]);
        n = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        check({tag, " stall cycles"}, 32'(n), 32'd3);
        if (r) begin
            e = exp_q.pop_front();
            check({tag, " rdata"}, rdata, e);
        end
        if (w) model_write(a, d, b);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rmem = 1'b0; wmem = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1;
        addr = '0; wdata = '0; rmem = 1'b0; wmem = 1'b0; be = '0;
        addr0 = '0; wdata0 = '0; rmem0 = 1'b0; wmem0 = 1'b0; be0 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset acc_cnt", 32'(acc_cnt), 32'd0);
        check("reset rdata lat0", rdata0, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload, then reset: the array keeps its contents but the counter clears
        access("pre10", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF, 4'hF);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("acc after reset", 32'(acc_cnt), 32'd0);
        access("rd10", 32'h10, 1'b1, 1'b0, 32'h0, 4'h0);
        check("acc after rd10", 32'(acc_cnt), 32'd1);
        idle();

        // Byte-lane write then back-to-back read through an aliased address
        access("pre20", 32'h20, 1'b0, 1'b1, 32'hAABBCCDD, 4'hF);
        idle();
        access("wr20", 32'h20, 1'b0, 1'b1, 32'h11223344, 4'b0101);
        access("rd20alias", 32'h1023, 1'b1, 1'b0, 32'h0, 4'h0);
        check("rd20 value", rdata, 32'hAA22CC44);
        idle();

        // Simultaneous read+write returns the pre-write word; be=0 write is a no-op
        access("pre30", 32'h30, 1'b0, 1'b1, 32'h9, 4'hF);
        idle();
        access("rw30", 32'h30, 1'b1, 1'b1, 32'h5, 4'hF);
        access("rd30", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0);
        access("wr30be0", 32'h30, 1'b0, 1'b1, 32'hFFFFFFFF, 4'h0);
        access("rd30b", 32'h30, 1'b1, 1'b0, 32'h0, 4'h0);
        idle();

        // Reset in the second stall cycle of a write aborts it
        access("pre40", 32'h40, 1'b0, 1'b1, 32'h0, 4'hF);
        idle();
        addr = 32'h40; wmem = 1'b1; wdata = 32'h77; be = 4'hF;
        @(posedge clk); #1;
        check("abort stall before", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("abort stall", 32'(stall), 32'd0);
        check("abort rdata", rdata, 32'h0);
        check("abort acc_cnt", 32'(acc_cnt), 32'd0);
        @(posedge clk); #1;
        wmem = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        access("rd40", 32'h40, 1'b1, 1'b0, 32'h0, 4'h0);
        check("acc after rd40", 32'(acc_cnt), 32'd1);

        // Counter saturates at 15 with CNT_W=4
        for (int i = 0; i < 20; i++) begin
            access("sat", 32'h10, 1'b1, 1'b0, 32'h0, 4'h0);
        end
        check("acc saturated", 32'(acc_cnt), 32'd15);
        idle();

        // LATENCY=0: same-cycle read of a word written on the previous edge
        addr0 = 32'h4; wmem0 = 1'b1; wdata0 = 32'hCAFEF00D; be0 = 4'hF;
        @(negedge clk);
        check("lat0 wr stall", 32'(stall0), 32'd0);
        @(posedge clk); #1;
        wmem0 = 1'b0; rmem0 = 1'b1;
        @(negedge clk);
        check("lat0 rd stall", 32'(stall0), 32'd0);
        check("lat0 rd", rdata0, 32'hCAFEF00D);
        @(posedge clk); #1;
        rmem0 = 1'b0; wmem0 = 1'b1; wdata0 = 32'h12345678; be0 = 4'b0011;
        @(posedge clk); #1;
        wmem0 = 1'b0; rmem0 = 1'b1;
        @(negedge clk);
        check("lat0 rd be", rdata0, 32'hCAFE5678);
        @(posedge clk); #1;
        rmem0 = 1'b0;
        check("lat0 acc_cnt", 32'(acc_cnt0), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
